bip_control_unit: RTL and testbench

Sequencer and instruction decoder of the accumulator processor; sits directly upstream of the accumulator datapath and drives all of its control inputs. It fetches 16-bit instructions from a synchronous-read program memory, decodes the 5-bit opcode / 11-bit operand format, and issues the datapath mux selects, ALU operation, accumulator write enable and data-memory read/write strobes. It runs a fixed 4-state-per-instruction sequence from a start pulse until a HLT instruction.

---
 rtl/bip_control_unit.sv | 228 ++++++++++++++++++++++
 tb/tb_bip_control_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control_unit.sv
// -----------------------------------------------------------------------------
// bip_control_unit
//
// Sequencer and instruction decoder for the accumulator processor. It fetches
// 16-bit instructions from a synchronous-read program memory, decodes the
// 5-bit opcode / 11-bit operand format and drives every control input of the
// accumulator datapath. Each instruction runs FETCH -> DECODE -> MEMORY -> EXEC.
// A HLT instruction leaves MEMORY for HALT, where the unit stays until reset.
//
// Ports:
//   i_clock        clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset
//   i_start        one-cycle start request, honoured only in IDLE
//   i_Instruction  program-memory read data, valid the cycle after o_rd_rom
//   o_PC           program-memory address
//   o_rd_rom       program-memory read strobe
//   o_SelA         accumulator input select (00 mem, 01 operand, 10 ALU)
//   o_SelB         ALU B select (0 mem, 1 operand)
//   o_WrAcc        accumulator write enable pulse
//   o_Op           ALU operation (0 add, 1 subtract)
//   o_Operand      operand field of IR, also the data-memory address
//   o_rd_ram       data-memory read strobe
//   o_wr_ram       data-memory write strobe pulse
//   o_halted       high while in HALT
//   o_cycles       (only with CYCLE_COUNTER_EN) saturating count of
//                  cycles spent executing instructions
//
// Optional feature macro: CYCLE_COUNTER_EN
// -----------------------------------------------------------------------------
module bip_control_unit #(
    parameter int NBITS_O = 11,
    parameter int NBITS_C = 5,
    parameter int NBITS_D = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_D-1:0] i_Instruction,
    output logic [NBITS_O-1:0] o_PC,
    output logic               o_rd_rom,
    output logic [1:0]         o_SelA,
    output logic               o_SelB,
    output logic               o_WrAcc,
    output logic               o_Op,
    output logic [NBITS_O-1:0] o_Operand,
    output logic               o_rd_ram,
    output logic               o_wr_ram,
    output logic               o_halted
`ifdef CYCLE_COUNTER_EN
    ,
    output logic [31:0]        o_cycles
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEMORY = 3'd3,
        ST_EXEC   = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [NBITS_C-1:0] OP_HLT  = 5'b00000;
    localparam logic [NBITS_C-1:0] OP_STO  = 5'b00001;
    localparam logic [NBITS_C-1:0] OP_LD   = 5'b00010;
    localparam logic [NBITS_C-1:0] OP_LDI  = 5'b00011;
    localparam logic [NBITS_C-1:0] OP_ADD  = 5'b00100;
    localparam logic [NBITS_C-1:0] OP_ADDI = 5'b00101;
    localparam logic [NBITS_C-1:0] OP_SUB  = 5'b00110;
    localparam logic [NBITS_C-1:0] OP_SUBI = 5'b00111;

    state_t               state;
    state_t               next_state;
    logic [NBITS_O-1:0]   pc;
    logic [NBITS_D-1:0]   ir;
    logic [NBITS_C-1:0]   opcode;

    // Decoded controls derived purely from IR, applied only in MEMORY/EXEC
    logic [1:0]           dec_sel_a;
    logic                 dec_sel_b;
    logic                 dec_op;
    logic                 dec_writes_acc;
    logic                 dec_reads_ram;
    logic                 dec_is_sto;

    // Raw strobes before reset gating
    logic                 rd_rom_raw;
    logic                 rd_ram_raw;
    logic                 wr_acc_raw;
    logic                 wr_ram_raw;

    assign opcode    = ir[NBITS_D-1:NBITS_O];
    assign o_Operand = ir[NBITS_O-1:0];
    assign o_PC      = pc;

    // Strobes are masked while reset is asserted so a reset landing in EXEC
    // cannot let an accumulator or memory write slip through.
    assign o_rd_rom  = rd_rom_raw & ~i_reset;
    assign o_rd_ram  = rd_ram_raw & ~i_reset;
    assign o_WrAcc   = wr_acc_raw & ~i_reset;
    assign o_wr_ram  = wr_ram_raw & ~i_reset;

    // State, program counter and instruction register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= ST_IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            state <= next_state;
            if (state == ST_DECODE) begin
                ir <= i_Instruction;
            end
            // PC wraps naturally at 2^NBITS_O
            if (state == ST_EXEC) begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Opcode decode; unknown opcodes fall through as NOP (no side effects)
    always_comb begin
        dec_sel_a      = 2'b00;
        dec_sel_b      = 1'b0;
        dec_op         = 1'b0;
        dec_writes_acc = 1'b0;
        dec_reads_ram  = 1'b0;
        dec_is_sto     = 1'b0;
        case (opcode)
            OP_STO: dec_is_sto = 1'b1;
            OP_LD: begin
                dec_sel_a      = 2'b00;
                dec_writes_acc = 1'b1;
                dec_reads_ram  = 1'b1;
            end
            OP_LDI: begin
                dec_sel_a      = 2'b01;
                dec_writes_acc = 1'b1;
            end
            OP_ADD: begin
                dec_sel_a      = 2'b10;
                dec_writes_acc = 1'b1;
                dec_reads_ram  = 1'b1;
            end
            OP_ADDI: begin
                dec_sel_a      = 2'b10;
                dec_sel_b      = 1'b1;
                dec_writes_acc = 1'b1;
            end
            OP_SUB: begin
                dec_sel_a      = 2'b10;
                dec_op         = 1'b1;
                dec_writes_acc = 1'b1;
                dec_reads_ram  = 1'b1;
            end
            OP_SUBI: begin
                dec_sel_a      = 2'b10;
                dec_sel_b      = 1'b1;
                dec_op         = 1'b1;
                dec_writes_acc = 1'b1;
            end
            default: ;
        endcase
    end

    // Next-state and control outputs
    always_comb begin
        next_state = state;
        rd_rom_raw = 1'b0;
        rd_ram_raw = 1'b0;
        wr_acc_raw = 1'b0;
        wr_ram_raw = 1'b0;
        o_SelA     = 2'b00;
        o_SelB     = 1'b0;
        o_Op       = 1'b0;
        o_halted   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_rom_raw = 1'b1;
                next_state = ST_DECODE;
            end
            ST_DECODE: begin
                next_state = ST_MEMORY;
            end
            ST_MEMORY: begin
                o_SelA     = dec_sel_a;
                o_SelB     = dec_sel_b;
                o_Op       = dec_op;
                rd_ram_raw = dec_reads_ram;
                next_state = (opcode == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            ST_EXEC: begin
                o_SelA     = dec_sel_a;
                o_SelB     = dec_sel_b;
                o_Op       = dec_op;
                wr_acc_raw = dec_writes_acc;
                wr_ram_raw = dec_is_sto;
                next_state = ST_FETCH;
            end
            ST_HALT: begin
                o_halted = 1'b1;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

`ifdef CYCLE_COUNTER_EN
    // Counts cycles spent executing instructions, saturating at all-ones
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_cycles <= '0;
        end else if ((state == ST_FETCH || state == ST_DECODE ||
                      state == ST_MEMORY || state == ST_EXEC) &&
                     (o_cycles != 32'hFFFF_FFFF)) begin
            o_cycles <= o_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bip_control_unit.sv
// -----------------------------------------------------------------------------
// tb_bip_control_unit
//
// Directed testbench for bip_control_unit. A small synchronous-read program
// memory is modelled here; each scenario loads a program, pulses start and
// checks the control outputs cycle by cycle against hand-computed values.
// -----------------------------------------------------------------------------
module tb_bip_control_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] instr;
    logic [10:0] pc;
    logic        rd_rom;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        wr_acc;
    logic        op;
    logic [10:0] operand;
    logic        rd_ram;
    logic        wr_ram;
    logic        halted;
`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycles;
`endif

    logic [15:0] rom [0:2047];

    int checks = 0;
    int errors = 0;

    bip_control_unit dut (
        .i_clock       (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_Instruction (instr),
        .o_PC          (pc),
        .o_rd_rom      (rd_rom),
        .o_SelA        (sel_a),
        .o_SelB        (sel_b),
        .o_WrAcc       (wr_acc),
        .o_Op          (op),
        .o_Operand     (operand),
        .o_rd_ram      (rd_ram),
        .o_wr_ram      (wr_ram),
        .o_halted      (halted)
`ifdef CYCLE_COUNTER_EN
        ,
        .o_cycles      (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read program memory
    always @(posedge clk) begin
        if (rd_rom) begin
            instr <= rom[pc];
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; sample one time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_rom(input logic [15:0] word);
        for (int i = 0; i < 2048; i++) begin
            rom[i] = word;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        instr = 16'h0000;
        fill_rom(16'h0000);

        // ---------------- Reset state ----------------
        step();
        step();
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_strobes", {28'h0, rd_rom, rd_ram, wr_acc, wr_ram}, 32'h0);
        check("rst_sel", {28'h0, sel_a, sel_b, op}, 32'h0);
        check("rst_operand", 32'(operand), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
`ifdef CYCLE_COUNTER_EN
        check("rst_cycles", cycles, 32'h0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("idle_rd_rom", 32'(rd_rom), 32'h0);
        check("idle_pc", 32'(pc), 32'h0);

        // ---------------- LDI 5, ADDI 3, HLT ----------------
        rom[0] = 16'h1805;
        rom[1] = 16'h2803;
        rom[2] = 16'h0000;
        pulse_start();                               // FETCH
        check("a_fetch_rd_rom", 32'(rd_rom), 32'h1);
        check("a_fetch_pc", 32'(pc), 32'h0);
        step();                                      // DECODE
        check("a_decode_rd_rom", 32'(rd_rom), 32'h0);
        step();                                      // MEMORY
        check("a_ldi_mem_wracc", 32'(wr_acc), 32'h0);
        check("a_ldi_mem_selA", 32'(sel_a), 32'h1);
        step();                                      // EXEC
        check("a_ldi_wracc", 32'(wr_acc), 32'h1);
        check("a_ldi_selA", 32'(sel_a), 32'h1);
        check("a_ldi_operand", 32'(operand), 32'h5);
        check("a_ldi_rd_ram", 32'(rd_ram), 32'h0);
        step();                                      // FETCH
        check("a_fetch2_pc", 32'(pc), 32'h1);
        check("a_fetch2_wracc", 32'(wr_acc), 32'h0);
        step();
        step();
        step();                                      // EXEC ADDI
        check("a_addi_wracc", 32'(wr_acc), 32'h1);
        check("a_addi_sel", {29'h0, sel_a, sel_b}, {29'h0, 2'b10, 1'b1});
        check("a_addi_op", 32'(op), 32'h0);
        check("a_addi_operand", 32'(operand), 32'h3);
        step();                                      // FETCH HLT
        check("a_fetch3_pc", 32'(pc), 32'h2);
        step();
        step();                                      // MEMORY HLT
        check("a_hlt_mem_halted", 32'(halted), 32'h0);
        check("a_hlt_mem_wracc", 32'(wr_acc), 32'h0);
        step();                                      // HALT
        check("a_halted", 32'(halted), 32'h1);
        check("a_halt_pc", 32'(pc), 32'h2);
`ifdef CYCLE_COUNTER_EN
        check("a_cycles", cycles, 32'd11);
        step();
        check("a_cycles_frozen", cycles, 32'd11);
`endif
        pulse_start();                               // start ignored in HALT
        step();
        check("a_start_ignored_halted", 32'(halted), 32'h1);
        check("a_start_ignored_rd_rom", 32'(rd_rom), 32'h0);
        check("a_start_ignored_pc", 32'(pc), 32'h2);

        // ---------------- LD A, SUB B, STO C, HLT ----------------
        do_reset();
        check("b_reset_pc", 32'(pc), 32'h0);
        check("b_reset_halted", 32'(halted), 32'h0);
        rom[0] = 16'h100A;
        rom[1] = 16'h300B;
        rom[2] = 16'h080C;
        rom[3] = 16'h0000;
        pulse_start();
        step();
        step();                                      // MEMORY LD
        check("b_ld_rd_ram", 32'(rd_ram), 32'h1);
        check("b_ld_operand", 32'(operand), 32'h00A);
        check("b_ld_selA", 32'(sel_a), 32'h0);
        step();                                      // EXEC LD
        check("b_ld_wracc", 32'(wr_acc), 32'h1);
        check("b_ld_exec_rd_ram", 32'(rd_ram), 32'h0);
        step();
        step();
        step();                                      // MEMORY SUB
        check("b_sub_rd_ram", 32'(rd_ram), 32'h1);
        check("b_sub_operand", 32'(operand), 32'h00B);
        check("b_sub_sel_op", {28'h0, sel_a, sel_b, op}, {28'h0, 2'b10, 1'b0, 1'b1});
        step();                                      // EXEC SUB
        check("b_sub_wracc", 32'(wr_acc), 32'h1);
        check("b_sub_op", 32'(op), 32'h1);
        step();
        step();
        step();                                      // MEMORY STO
        check("b_sto_mem_rd_ram", 32'(rd_ram), 32'h0);
        check("b_sto_mem_wr_ram", 32'(wr_ram), 32'h0);
        step();                                      // EXEC STO
        check("b_sto_wr_ram", 32'(wr_ram), 32'h1);
        check("b_sto_wracc", 32'(wr_acc), 32'h0);
        check("b_sto_operand", 32'(operand), 32'h00C);
        step();                                      // FETCH HLT
        check("b_sto_wr_ram_single", 32'(wr_ram), 32'h0);
        check("b_fetch_pc", 32'(pc), 32'h3);

        // ---------------- NOP opcode and PC wrap ----------------
        do_reset();
        fill_rom(16'hF800);
        pulse_start();
        step();
        step();                                      // MEMORY NOP
        check("c_nop_mem_rd_ram", 32'(rd_ram), 32'h0);
        step();                                      // EXEC NOP
        check("c_nop_strobes", {29'h0, wr_acc, wr_ram, rd_ram}, 32'h0);
        step();                                      // FETCH next
        check("c_nop_pc", 32'(pc), 32'h1);
        check("c_nop_rd_rom", 32'(rd_rom), 32'h1);
        for (int i = 1; i < 2047; i++) begin
            step();
            step();
            step();
            step();
        end
        check("c_pc_top", 32'(pc), 32'h7FF);
        check("c_pc_top_rd_rom", 32'(rd_rom), 32'h1);
        step();
        step();
        step();
        step();
        check("c_pc_wrap", 32'(pc), 32'h000);
        check("c_pc_wrap_halted", 32'(halted), 32'h0);

        // ---------------- Reset during EXEC of ADD ----------------
        do_reset();
        fill_rom(16'h0000);
        rom[0] = 16'h2005;
        pulse_start();
        step();
        step();                                      // MEMORY ADD
        check("d_add_rd_ram", 32'(rd_ram), 32'h1);
        check("d_add_selA", 32'(sel_a), 32'h2);
        step();                                      // EXEC ADD
        reset = 1'b1;
        #1;
        check("d_reset_wracc", 32'(wr_acc), 32'h0);
        step();
        reset = 1'b0;
        #1;
        check("d_after_pc", 32'(pc), 32'h0);
        check("d_after_strobes", {28'h0, rd_rom, rd_ram, wr_acc, wr_ram}, 32'h0);
        step();
        step();
        check("d_idle_rd_rom", 32'(rd_rom), 32'h0);
        check("d_idle_pc", 32'(pc), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
